multicycle_controller: RTL and testbench

- Multi-cycle sequencer for the RV32 subset datapath: R-type, I-type ALU, LW, SW, BEQ/BNE, JAL, LUI.
- One instruction executes over several cycles. A single shared instruction/data memory port uses a req/ready handshake.
- Drives the PC/IR write enables, memory address select, register-file write, result mux, immediate-extender select, and alu_op. alu_op feeds the existing second-level ALU decoder unchanged.
- Adds memory-timeout and illegal-opcode fault handling.

---
 rtl/multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32 subset sequencer with memory-timeout and illegal-opcode faults
//
// Purpose: steps one instruction over several cycles, sharing a single
// instruction/data memory port through a mem_req/mem_ready handshake.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   opcode, funct3       instruction fields from IR
//   zero                 ALU zero flag
//   mem_ready            memory completes the current request this cycle
//   mem_req, mem_we      memory request / write qualifier
//   sel_adr              memory address select (0 PC, 1 ALUOut)
//   ir_we, pc_we, sel_pc IR/PC write enables and PC source select
//   rf_we, sel_result    register-file write and result mux
//   sel_alu_src_b        ALU B select (0 rs2, 1 immediate)
//   alu_op               to second-level ALU decoder
//   sel_ext              immediate format select
//   halted, fault_code   sticky fault status
//   state_dbg            current state encoding
//   cycle_cnt, instret_cnt  performance counters (MC_PERF_CNT_EN only)
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             sel_adr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             sel_pc,
  output logic             rf_we,
  output logic [1:0]       sel_result,
  output logic             sel_alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       sel_ext,
  output logic             halted,
  output logic [1:0]       fault_code,
`ifdef MC_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_LOADWB = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_EXEC_I = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_LUI    = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_controller: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  logic [3:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [1:0] fault, fault_nxt;
  logic       in_mem_state;
  logic       timeout;
  logic       br_taken;

  assign in_mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // The counter has already absorbed MEM_TIMEOUT wait cycles; one more miss faults.
  assign timeout  = in_mem_state && !mem_ready && (wait_cnt == TIMEOUT_LIM);
  assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_comb begin
    state_nxt = state;
    fault_nxt = fault;
    unique case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_HALT;
          fault_nxt = F_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_B:         state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          OP_LUI:       state_nxt = S_LUI;
          default: begin
            state_nxt = S_HALT;
            fault_nxt = F_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          state_nxt = S_LOADWB;
        end else if (timeout) begin
          state_nxt = S_HALT;
          fault_nxt = F_TIMEOUT;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end else if (timeout) begin
          state_nxt = S_HALT;
          fault_nxt = F_TIMEOUT;
        end
      end
      S_EXEC_R, S_EXEC_I:               state_nxt = S_ALUWB;
      S_LOADWB, S_ALUWB, S_BRANCH,
      S_JAL, S_LUI:                     state_nxt = S_FETCH;
      S_HALT:                           state_nxt = S_HALT;
      default:                          state_nxt = S_HALT;
    endcase
  end

  // Counter restarts whenever a memory state is freshly entered.
  always_comb begin
    wait_nxt = wait_cnt;
    if ((state_nxt != state) &&
        ((state_nxt == S_FETCH) || (state_nxt == S_MEMRD) || (state_nxt == S_MEMWR))) begin
      wait_nxt = 8'd0;
    end else if (in_mem_state && !mem_ready && !timeout) begin
      wait_nxt = wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      fault    <= F_NONE;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fault    <= fault_nxt;
    end
  end

  // Outputs are gated by rst_n so nothing (in particular mem_we) escapes while in reset.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    sel_adr       = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    sel_pc        = 1'b0;
    rf_we         = 1'b0;
    sel_result    = 2'b00;
    sel_alu_src_b = 1'b0;
    alu_op        = 2'b00;
    sel_ext       = 3'b000;
    halted        = 1'b0;
    fault_code    = 2'b00;
    state_dbg     = 4'd0;
    if (rst_n) begin
      state_dbg  = state;
      fault_code = fault;
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        S_DECODE: begin
          unique case (opcode)
            OP_SW:   sel_ext = 3'b001;
            OP_B:    sel_ext = 3'b010;
            OP_LUI:  sel_ext = 3'b011;
            OP_JAL:  sel_ext = 3'b100;
            default: sel_ext = 3'b000;
          endcase
        end
        S_MEMADR: begin
          sel_alu_src_b = 1'b1;
          sel_ext       = (opcode == OP_SW) ? 3'b001 : 3'b000;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          sel_adr = 1'b1;
        end
        S_LOADWB: begin
          rf_we      = 1'b1;
          sel_result = 2'b01;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          sel_adr = 1'b1;
        end
        S_EXEC_R: alu_op = 2'b01;
        S_EXEC_I: begin
          alu_op        = 2'b10;
          sel_alu_src_b = 1'b1;
        end
        S_ALUWB: rf_we = 1'b1;
        S_BRANCH: begin
          alu_op  = 2'b01;
          sel_ext = 3'b010;
          pc_we   = br_taken;
          sel_pc  = br_taken;
        end
        S_JAL: begin
          rf_we      = 1'b1;
          sel_result = 2'b10;
          pc_we      = 1'b1;
          sel_pc     = 1'b1;
          sel_ext    = 3'b100;
        end
        S_LUI: begin
          rf_we      = 1'b1;
          sel_result = 2'b11;
          sel_ext    = 3'b011;
        end
        default: halted = 1'b1;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state != S_HALT) begin
      cycle_q <= cycle_q + 1'b1;
      if ((state != S_FETCH) && (state_nxt == S_FETCH)) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign cycle_cnt   = rst_n ? cycle_q : '0;
  assign instret_cnt = rst_n ? instret_q : '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, sel_adr, ir_we, pc_we, sel_pc, rf_we;
  logic [1:0] sel_result, alu_op, fault_code;
  logic       sel_alu_src_b, halted;
  logic [2:0] sel_ext;
  logic [3:0] state_dbg;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .sel_adr(sel_adr),
    .ir_we(ir_we), .pc_we(pc_we), .sel_pc(sel_pc), .rf_we(rf_we),
    .sel_result(sel_result), .sel_alu_src_b(sel_alu_src_b), .alu_op(alu_op),
    .sel_ext(sel_ext), .halted(halted), .fault_code(fault_code),
`ifdef MC_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {state, req,we,adr,irw,pcw,selpc,rfw, result, srcb, alu_op, ext, halted, fault}
  logic [21:0] outs;
  assign outs = {state_dbg, mem_req, mem_we, sel_adr, ir_we, pc_we, sel_pc, rf_we,
                 sel_result, sel_alu_src_b, alu_op, sel_ext, halted, fault_code};

  function automatic logic [21:0] ev(input logic [3:0] st, input logic [6:0] strb,
                                     input logic [1:0] res, input logic srcb,
                                     input logic [1:0] aop, input logic [2:0] ext,
                                     input logic hlt, input logic [1:0] fc);
    return {st, strb, res, srcb, aop, ext, hlt, fc};
  endfunction

  localparam logic [21:0] E_FETCH_RDY = {4'd0, 7'b1001100, 11'd0};
  localparam logic [21:0] E_FETCH_WT  = {4'd0, 7'b1000000, 11'd0};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 7'b0100011;
    #1;
    n_checks++;
    if (outs !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h expected %h", outs, 22'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (outs !== E_FETCH_WT) begin
      n_fail++;
      $display("FAIL reset_fetch got %h expected %h", outs, E_FETCH_WT);
    end
  endtask

  task automatic test_add();
    logic [21:0] exp_t [5];
    exp_t[0] = E_FETCH_RDY;
    exp_t[1] = ev(4'd1, 7'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00);
    exp_t[2] = ev(4'd6, 7'b0, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0, 2'b00);
    exp_t[3] = ev(4'd8, 7'b0000001, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00);
    exp_t[4] = E_FETCH_RDY;
    do_reset();
    opcode = 7'b0110011;
    funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (outs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL add_cycle%0d got %h expected %h", i + 1, outs, exp_t[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    logic [21:0] exp_t [9];
    logic        rdy_t [9];
    int          wb_seen;
    exp_t[0] = E_FETCH_RDY;                                                  rdy_t[0] = 1'b1;
    exp_t[1] = ev(4'd1, 7'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00);      rdy_t[1] = 1'b0;
    exp_t[2] = ev(4'd2, 7'b0, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0, 2'b00);      rdy_t[2] = 1'b0;
    for (int i = 3; i < 7; i++) begin
      exp_t[i] = ev(4'd3, 7'b1010000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00);
      rdy_t[i] = (i == 6);
    end
    exp_t[7] = ev(4'd4, 7'b0000001, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00); rdy_t[7] = 1'b0;
    exp_t[8] = E_FETCH_WT;                                                   rdy_t[8] = 1'b0;
    wb_seen = 0;
    do_reset();
    opcode = 7'b0000011;
    funct3 = 3'b010;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy_t[i];
      #1;
      if (rf_we && sel_result == 2'b01) wb_seen++;
      n_checks++;
      if (outs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL lw_cycle%0d got %h expected %h", i + 1, outs, exp_t[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (wb_seen !== 1) begin
      n_fail++;
      $display("FAIL lw_writeback_count got %0d expected 1", wb_seen);
    end
  endtask

  task automatic test_sw();
    logic [21:0] exp_t [5];
    exp_t[0] = E_FETCH_RDY;
    exp_t[1] = ev(4'd1, 7'b0, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00);
    exp_t[2] = ev(4'd2, 7'b0, 2'b00, 1'b1, 2'b00, 3'b001, 1'b0, 2'b00);
    exp_t[3] = ev(4'd5, 7'b1110000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00);
    exp_t[4] = E_FETCH_RDY;
    do_reset();
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (outs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL sw_cycle%0d got %h expected %h", i + 1, outs, exp_t[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jal_lui();
    logic [21:0] exp_j [4];
    logic [21:0] exp_l [4];
    exp_j[0] = E_FETCH_RDY;
    exp_j[1] = ev(4'd1, 7'b0, 2'b00, 1'b0, 2'b00, 3'b100, 1'b0, 2'b00);
    exp_j[2] = ev(4'd10, 7'b0000111, 2'b10, 1'b0, 2'b00, 3'b100, 1'b0, 2'b00);
    exp_j[3] = E_FETCH_RDY;
    exp_l[0] = E_FETCH_RDY;
    exp_l[1] = ev(4'd1, 7'b0, 2'b00, 1'b0, 2'b00, 3'b011, 1'b0, 2'b00);
    exp_l[2] = ev(4'd11, 7'b0000001, 2'b11, 1'b0, 2'b00, 3'b011, 1'b0, 2'b00);
    exp_l[3] = E_FETCH_RDY;
    do_reset();
    opcode = 7'b1101111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (outs !== exp_j[i]) begin
        n_fail++;
        $display("FAIL jal_cycle%0d got %h expected %h", i + 1, outs, exp_j[i]);
      end
      @(negedge clk);
    end
    do_reset();
    opcode = 7'b0110111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (outs !== exp_l[i]) begin
        n_fail++;
        $display("FAIL lui_cycle%0d got %h expected %h", i + 1, outs, exp_l[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3_t [5];
    logic       z_t  [5];
    logic       tk_t [5];
    logic [21:0] exp_v;
    f3_t[0] = 3'b000; z_t[0] = 1'b1; tk_t[0] = 1'b1;
    f3_t[1] = 3'b001; z_t[1] = 1'b1; tk_t[1] = 1'b0;
    f3_t[2] = 3'b100; z_t[2] = 1'b1; tk_t[2] = 1'b0;
    f3_t[3] = 3'b001; z_t[3] = 1'b0; tk_t[3] = 1'b1;
    f3_t[4] = 3'b000; z_t[4] = 1'b0; tk_t[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_reset();
      opcode = 7'b1100011;
      funct3 = f3_t[k];
      zero   = z_t[k];
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1;
        case (i)
          0: exp_v = E_FETCH_RDY;
          1: exp_v = ev(4'd1, 7'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 2'b00);
          2: exp_v = ev(4'd9, tk_t[k] ? 7'b0000110 : 7'b0, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 2'b00);
          default: exp_v = E_FETCH_RDY;
        endcase
        #1;
        n_checks++;
        if (outs !== exp_v) begin
          n_fail++;
          $display("FAIL branch%0d_cycle%0d got %h expected %h", k, i + 1, outs, exp_v);
        end
        @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [21:0] exp_h;
    exp_h = ev(4'd12, 7'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 2'b01);
    do_reset();
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if (outs !== exp_h) begin
        n_fail++;
        $display("FAIL illegal_halt_cycle%0d got %h expected %h", i, outs, exp_h);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic [21:0] exp_h;
    int          budget;
    exp_h = ev(4'd12, 7'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 2'b10);
    do_reset();
    opcode = 7'b0110011;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      n_checks++;
      if ({state_dbg, mem_req, halted} !== {4'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL timeout_wait%0d got st=%0d req=%b halt=%b expected st=0 req=1 halt=0",
                 i, state_dbg, mem_req, halted);
      end
      @(negedge clk);
    end
    budget = 0;
    #1;
    while (!halted && budget < 10) begin
      @(negedge clk);
      #1;
      budget++;
    end
    n_checks++;
    if (outs !== exp_h) begin
      n_fail++;
      $display("FAIL timeout_halt got %h expected %h", outs, exp_h);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (outs !== exp_h) begin
      n_fail++;
      $display("FAIL timeout_halt_hold got %h expected %h", outs, exp_h);
    end
  endtask

  task automatic test_reset_mid_memwr();
    logic [21:0] exp_w;
    exp_w = ev(4'd5, 7'b1110000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00);
    do_reset();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (outs !== exp_w) begin
      n_fail++;
      $display("FAIL memwr_before_reset got %h expected %h", outs, exp_w);
    end
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs !== 22'd0) begin
      n_fail++;
      $display("FAIL memwr_reset_outputs got %h expected %h", outs, 22'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (outs !== E_FETCH_WT) begin
      n_fail++;
      $display("FAIL memwr_reset_fetch got %h expected %h", outs, E_FETCH_WT);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_jal_lui();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_memwr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
